// File: rtl/pong_pkg.sv
// Shared definitions for the pong game: state encoding, BCD limits and
// the default game parameters used by the controller, pixel generator and
// text overlay.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_NEWGAME = 2'd0,
        ST_PLAY    = 2'd1,
        ST_NEWBALL = 2'd2,
        ST_OVER    = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX         = 4'd9;
    localparam int         DEF_LIVES       = 3;
    localparam int         DEF_SERVE_DELAY = 120;

    // Next value of a 2-digit BCD count {tens, ones}; holds at 99.
    function automatic logic [7:0] bcd2_inc(input logic [3:0] tens,
                                            input logic [3:0] ones);
        logic [7:0] res;
        if (ones != BCD_MAX) begin
            res = {tens, ones + 4'd1};
        end else if (tens != BCD_MAX) begin
            res = {tens + 4'd1, 4'd0};
        end else begin
            res = {tens, ones};
        end
        return res;
    endfunction

endpackage

// File: rtl/pong_game_ctrl_bcd_counter2.sv
// Two-digit BCD score counter: synchronous clear, increment enable,
// saturates at 99, asynchronous reset to 00.
module bcd_counter2
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] bcd1,
    output logic [3:0] bcd0
);

    logic [3:0] tens_r;
    logic [3:0] ones_r;

    // Score digits: clear has priority over increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tens_r <= 4'd0;
            ones_r <= 4'd0;
        end else if (clr) begin
            tens_r <= 4'd0;
            ones_r <= 4'd0;
        end else if (inc) begin
            {tens_r, ones_r} <= bcd2_inc(tens_r, ones_r);
        end else begin
            tens_r <= tens_r;
            ones_r <= ones_r;
        end
    end

    assign bcd1 = tens_r;
    assign bcd0 = ones_r;

endmodule

// File: rtl/pong_game_ctrl.sv
// Game-level sequencer for pong: freezes/re-serves the ball, ends the game
// when the last ball is lost, and keeps the BCD score and remaining lives.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int LIVES       = DEF_LIVES,
    parameter int SERVE_DELAY = DEF_SERVE_DELAY
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       refresh_tick,
    input  logic       start,
    input  logic       hit,
    input  logic       miss,
    output logic       ball_reset,
    output logic       ball_freeze,
    output logic       game_over,
    output logic [3:0] score_bcd1,
    output logic [3:0] score_bcd0,
    output logic [1:0] lives_left,
    output logic [1:0] state_o
);

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [7:0] DELAY_INIT = 8'(SERVE_DELAY);

    state_t     state_r;
    state_t     state_s;
    logic [7:0] timer_r;
    logic [7:0] timer_s;
    logic [1:0] lives_r;
    logic [1:0] lives_s;
    logic       start_d_r;
    logic       start_pulse_s;
    logic       ball_reset_r;
    logic       ball_reset_s;
    logic       freeze_r;
    logic       over_r;
    logic       score_clr_s;
    logic       score_inc_s;

    // A held button produces a single pulse on its rising edge.
    assign start_pulse_s = start & ~start_d_r;

    // Next-state, countdown, lives and score-control decode.
    always_comb begin
        state_s      = state_r;
        timer_s      = timer_r;
        lives_s      = lives_r;
        ball_reset_s = 1'b0;
        score_clr_s  = 1'b0;
        score_inc_s  = 1'b0;
        case (state_r)
            ST_NEWGAME: begin
                if (start_pulse_s) begin
                    score_clr_s  = 1'b1;
                    lives_s      = LIVES_INIT;
                    ball_reset_s = 1'b1;
                    state_s      = ST_PLAY;
                end else begin
                    state_s = ST_NEWGAME;
                end
            end
            ST_PLAY: begin
                // A miss in the same cycle as a hit wins; the hit is dropped.
                if (miss) begin
                    if (lives_r > 2'd1) begin
                        lives_s      = lives_r - 2'd1;
                        timer_s      = DELAY_INIT;
                        ball_reset_s = 1'b1;
                        state_s      = ST_NEWBALL;
                    end else begin
                        lives_s = 2'd0;
                        state_s = ST_OVER;
                    end
                end else if (hit) begin
                    score_inc_s = 1'b1;
                end else begin
                    state_s = ST_PLAY;
                end
            end
            ST_NEWBALL: begin
                // Countdown advances only on frame ticks.
                if (refresh_tick) begin
                    if (timer_r == 8'd1) begin
                        timer_s = 8'd0;
                        state_s = ST_PLAY;
                    end else begin
                        timer_s = timer_r - 8'd1;
                    end
                end else begin
                    timer_s = timer_r;
                end
            end
            ST_OVER: begin
                // Score and lives stay visible until the player restarts.
                if (start_pulse_s) begin
                    state_s = ST_NEWGAME;
                end else begin
                    state_s = ST_OVER;
                end
            end
            default: begin
                state_s = ST_NEWGAME;
            end
        endcase
    end

    // Control state and registered outputs; output flops load the decode
    // of the next state so they always match the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_NEWGAME;
            timer_r      <= 8'd0;
            lives_r      <= LIVES_INIT;
            start_d_r    <= 1'b0;
            ball_reset_r <= 1'b0;
            freeze_r     <= 1'b1;
            over_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            timer_r      <= timer_s;
            lives_r      <= lives_s;
            start_d_r    <= start;
            ball_reset_r <= ball_reset_s;
            freeze_r     <= (state_s != ST_PLAY);
            over_r       <= (state_s == ST_OVER);
        end
    end

    bcd_counter2 u_score (
        .clk   (clk),
        .reset (reset),
        .clr   (score_clr_s),
        .inc   (score_inc_s),
        .bcd1  (score_bcd1),
        .bcd0  (score_bcd0)
    );

    assign ball_reset  = ball_reset_r;
    assign ball_freeze = freeze_r;
    assign game_over   = over_r;
    assign lives_left  = lives_r;
    assign state_o     = state_r;

endmodule
